mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_AW, 17, RAM byte-address width; RAM holds 2^RAM_AW bytes.
REQ-002 Parameter RX_DEPTH, 4, input-byte FIFO depth (power of 2).
REQ-003 Parameter TX_DEPTH, 8, output-byte FIFO depth (power of 2).
REQ-004 clk_in  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_in  in  1  reset, synchronous, active-high.
REQ-006 cpu_a  in  32  CPU byte address; bits [17:0] decoded, bits [31:18] ignored.
REQ-007 cpu_wr  in  1  1 = write, 0 = read.
REQ-008 cpu_wdata  in  8  CPU write byte.
REQ-009 cpu_rdata  out  8  read byte, registered.
REQ-010 cpu_rdy  out  1  combinational; 0 = CPU must freeze and hold cpu_a, cpu_wr and cpu_wdata.
REQ-011 rx_valid  in  1, rx_data  in  8, rx_ready  out  1  input byte stream; transfer when valid & ready.
REQ-012 tx_valid  out  1, tx_data  out  8, tx_ready  in  1  output byte stream; transfer when valid & ready.
REQ-013 prog_stop  out  1  sticky program-stop flag.

Function
REQ-014 Decode: cpu_a[17:16] != 2'b11 selects RAM at cpu_a[RAM_AW-1:0]; cpu_a[17:16] == 2'b11 selects IO.
REQ-015 RAM read: cpu_rdata = mem[addr] at the edge after the address is presented (1-cycle latency; CPU samples on the following cycle); RAM reads never stall.
REQ-016 RAM write: mem[addr] <= cpu_wdata at the same edge; no stall; cpu_rdata unchanged.
REQ-017 IO read 0x30000: pops the RX FIFO head into cpu_rdata; if the RX FIFO is empty, cpu_rdy = 0, nothing pops, and cpu_rdata holds until a byte is available.
REQ-018 IO read 0x30004: cpu_rdata <= cycle counter[7:0], and the full 32-bit counter is captured into a snapshot register at the same edge.
REQ-019 IO reads 0x30005..0x30007: return snapshot bytes [15:8], [23:16] and [31:24] respectively; the counter is not re-sampled.
REQ-020 Cycle counter: 32 bits; 0 at reset; +1 every cycle; wraps 0xFFFFFFFF -> 0; runs while the CPU is stalled.
REQ-021 IO write 0x30000, data != 0x00: pushes the byte to the TX FIFO; if the TX FIFO is full, cpu_rdy = 0 until space frees.
REQ-022 IO write 0x30000, data == 0x00: ignored; no push; cpu_rdy = 1.
REQ-023 IO write 0x30004: pushes 0x00 to the TX FIFO (stalls if full) and sets prog_stop = 1 at the push edge; prog_stop stays 1 until reset.
REQ-024 Any other IO address: reads return 0x00; writes have no effect; no stall.
REQ-025 cpu_rdy = 1 except in the conditions of REQ-017, REQ-021 and REQ-023; cpu_rdy must not depend on cpu_rdy itself (no combinational loop).
REQ-026 RX FIFO: rx_ready = !rx_full. A simultaneous push and pop is allowed when the FIFO is non-empty; count unchanged; the popped byte is the old head.
REQ-027 RX FIFO empty with an rx push in the same cycle as an 0x30000 read: the read still stalls that cycle (no bypass) and completes next cycle.
REQ-028 TX FIFO: tx_valid = !tx_empty; tx_data = head. A simultaneous pop (tx_ready) and push is allowed when the FIFO is non-empty.
REQ-029 TX FIFO full with tx_ready = 1: the CPU push still stalls this cycle; cpu_rdy is not derived from tx_ready.
REQ-030 FIFO pointers wrap modulo depth; occupancy counters are log2(depth)+1 bits wide; no overflow or underflow under any input sequence.

Reset
REQ-031 While rst_in = 1 at a clock edge: cpu_rdata = 0x00, prog_stop = 0, counter = 0, snapshot = 0, both FIFOs empty.
REQ-032 During and after reset: tx_valid = 0, rx_ready = 1, cpu_rdy = 1.
REQ-033 Reset asserted mid-stall: the pending IO access is discarded; no push and no pop occur at the reset edge.
REQ-034 RAM contents are not cleared by reset.

Verification
REQ-035 Write 0xA5 to 0x00123, then read 0x00123 -> cpu_rdata = 0xA5 one cycle after the read address; cpu_rdy stays 1 throughout.
REQ-036 Read 0x30000 with RX empty for 3 cycles, then rx byte 0x41 -> cpu_rdy = 0 for the 3 cycles plus the push cycle, then cpu_rdata = 0x41 and RX is empty again.
REQ-037 With tx_ready = 0: write 0x30000 nine times with 0x31 -> 8 pushes accepted, cpu_rdy = 0 on the ninth; one tx_ready pulse -> the ninth completes.
REQ-038 Write 0x00 to 0x30000 -> no tx_valid; write to 0x30004 -> tx_data = 0x00 is emitted and prog_stop = 1 until rst_in.
REQ-039 Force the counter to 0x12345678 at the 0x30004 read, then read 0x30005..0x30007 on later cycles -> returns 0x78, 0x56, 0x34, 0x12.
REQ-040 Assert rst_in while a TX-full stall is pending -> the FIFO is empty after reset, cpu_rdy = 1, and the pending byte is never emitted.

Source files
------------

// File: rtl/mem_io_responder.sv
// Byte-wide CPU slave: on-chip RAM plus memory-mapped RX/TX byte FIFOs,
// a free-running cycle counter with snapshot readout and a sticky stop flag.
module mem_io_responder #(
  parameter int RAM_AW   = 17,
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  logic [7:0]       ram_r    [2**RAM_AW];
  logic [7:0]       rx_mem_r [RX_DEPTH];
  logic [7:0]       tx_mem_r [TX_DEPTH];
  logic [RX_AW-1:0] rx_rd_ptr_r, rx_wr_ptr_r;
  logic [RX_AW:0]   rx_cnt_r;
  logic [TX_AW-1:0] tx_rd_ptr_r, tx_wr_ptr_r;
  logic [TX_AW:0]   tx_cnt_r;
  logic [31:0]      cycle_cnt_r;
  logic [31:0]      snap_r;
  logic [7:0]       rdata_r;
  logic             prog_stop_r;

  logic             is_io_s;
  logic [15:0]      io_off_s;
  logic             rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
  logic             rx_rd_s, tx_wr_s, stall_s;
  logic             rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
  logic [7:0]       tx_push_data_s;
  logic             ram_we_s;
  logic             unused_s;

  // Address decode, FIFO status and handshake qualification; reset masks every transfer.
  always_comb begin
    is_io_s        = (cpu_a[17:16] == 2'b11);
    io_off_s       = cpu_a[15:0];
    rx_empty_s     = (rx_cnt_r == {(RX_AW+1){1'b0}});
    rx_full_s      = rx_cnt_r[RX_AW];
    tx_empty_s     = (tx_cnt_r == {(TX_AW+1){1'b0}});
    tx_full_s      = tx_cnt_r[TX_AW];
    rx_rd_s        = is_io_s && !cpu_wr && (io_off_s == 16'h0000);
    tx_wr_s        = is_io_s && cpu_wr &&
                     (((io_off_s == 16'h0000) && (cpu_wdata != 8'h00)) || (io_off_s == 16'h0004));
    stall_s        = !rst_in && ((rx_rd_s && rx_empty_s) || (tx_wr_s && tx_full_s));
    rx_pop_s       = !rst_in && rx_rd_s && !rx_empty_s;
    rx_push_s      = !rst_in && rx_valid && !rx_full_s;
    tx_pop_s       = !rst_in && tx_ready && !tx_empty_s;
    tx_push_s      = !rst_in && tx_wr_s && !tx_full_s;
    tx_push_data_s = (io_off_s == 16'h0004) ? 8'h00 : cpu_wdata;
    ram_we_s       = !rst_in && !is_io_s && cpu_wr;
  end

  assign cpu_rdy   = !stall_s;
  assign rx_ready  = rst_in || !rx_full_s;
  assign tx_valid  = !rst_in && !tx_empty_s;
  assign tx_data   = tx_mem_r[tx_rd_ptr_r];
  assign cpu_rdata = rdata_r;
  assign prog_stop = prog_stop_r;
  assign unused_s  = ^{cpu_a[31:18], snap_r[7:0]};

  // RAM array write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (ram_we_s) ram_r[cpu_a[RAM_AW-1:0]] <= cpu_wdata;
  end

  // FIFO data storage.
  always_ff @(posedge clk_in) begin
    if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data;
    if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= tx_push_data_s;
  end

  // Control state: counter, FIFO pointers/occupancy, read data, snapshot and stop flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt_r <= 32'h0000_0000;
      snap_r      <= 32'h0000_0000;
      rdata_r     <= 8'h00;
      prog_stop_r <= 1'b0;
      rx_rd_ptr_r <= {RX_AW{1'b0}};
      rx_wr_ptr_r <= {RX_AW{1'b0}};
      rx_cnt_r    <= {(RX_AW+1){1'b0}};
      tx_rd_ptr_r <= {TX_AW{1'b0}};
      tx_wr_ptr_r <= {TX_AW{1'b0}};
      tx_cnt_r    <= {(TX_AW+1){1'b0}};
    end else begin
      cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;

      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_AW'(1'b1);
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_AW'(1'b1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + (RX_AW+1)'(1'b1);
        2'b01:   rx_cnt_r <= rx_cnt_r - (RX_AW+1)'(1'b1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase

      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_AW'(1'b1);
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_AW'(1'b1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + (TX_AW+1)'(1'b1);
        2'b01:   tx_cnt_r <= tx_cnt_r - (TX_AW+1)'(1'b1);
        default: tx_cnt_r <= tx_cnt_r;
      endcase

      // Writes never touch read data; a stalled access leaves everything alone.
      if (!stall_s && !cpu_wr) begin
        if (!is_io_s) begin
          rdata_r <= ram_r[cpu_a[RAM_AW-1:0]];
        end else begin
          case (io_off_s)
            16'h0000: rdata_r <= rx_mem_r[rx_rd_ptr_r];
            16'h0004: begin
              rdata_r <= cycle_cnt_r[7:0];
              snap_r  <= cycle_cnt_r;
            end
            16'h0005: rdata_r <= snap_r[15:8];
            16'h0006: rdata_r <= snap_r[23:16];
            16'h0007: rdata_r <= snap_r[31:24];
            default:  rdata_r <= 8'h00;
          endcase
        end
      end

      if (tx_push_s && (io_off_s == 16'h0004)) prog_stop_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: hand-derived vector table, directed corner
// sequences, then randomized traffic scored against a queue-based model.
module tb_mem_io_responder;
  localparam int RXD = 4;
  localparam int TXD = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        prog_stop;

  int checks   = 0;
  int failures = 0;

  mem_io_responder #(.RAM_AW(17), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .prog_stop(prog_stop)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [7:0]  m_rxq[$];
  logic [7:0]  m_txq[$];
  logic [7:0]  m_mem[int];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic [7:0]  m_rdata;
  bit          m_rdata_known;
  bit          m_prog;
  bit          last_rdy;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        rdy;
    logic [7:0]  rdata;
  } vec_t;

  vec_t        vecs[11];
  logic [17:0] pool[5];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_rdy();
    bit          io;
    logic [15:0] off;
    io  = (cpu_a[17:16] == 2'b11);
    off = cpu_a[15:0];
    if (rst_in) return 1'b1;
    if (io && !cpu_wr && off == 16'h0000 && m_rxq.size() == 0) return 1'b0;
    if (io && cpu_wr && ((off == 16'h0000 && cpu_wdata != 8'h00) || off == 16'h0004) &&
        m_txq.size() == TXD) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_step(input bit rdy);
    bit          io, tx_pop, rx_push, tx_push, rx_pop;
    logic [15:0] off;
    logic [7:0]  tx_val;
    if (rst_in) begin
      m_rxq.delete();
      m_txq.delete();
      m_cnt = 32'h0; m_snap = 32'h0; m_rdata = 8'h00; m_rdata_known = 1'b1; m_prog = 1'b0;
      return;
    end
    io      = (cpu_a[17:16] == 2'b11);
    off     = cpu_a[15:0];
    tx_pop  = (m_txq.size() > 0) && tx_ready;
    rx_push = rx_valid && (m_rxq.size() < RXD);
    tx_push = 1'b0; rx_pop = 1'b0; tx_val = 8'h00;
    if (rdy) begin
      if (!io) begin
        if (cpu_wr) m_mem[int'(cpu_a[16:0])] = cpu_wdata;
        else if (m_mem.exists(int'(cpu_a[16:0]))) begin
          m_rdata = m_mem[int'(cpu_a[16:0])]; m_rdata_known = 1'b1;
        end else m_rdata_known = 1'b0;
      end else if (!cpu_wr) begin
        case (off)
          16'h0000: begin m_rdata = m_rxq[0]; rx_pop = 1'b1; end
          16'h0004: begin m_rdata = m_cnt[7:0]; m_snap = m_cnt; end
          16'h0005: m_rdata = m_snap[15:8];
          16'h0006: m_rdata = m_snap[23:16];
          16'h0007: m_rdata = m_snap[31:24];
          default:  m_rdata = 8'h00;
        endcase
        m_rdata_known = 1'b1;
      end else if (off == 16'h0000 && cpu_wdata != 8'h00) begin
        tx_push = 1'b1; tx_val = cpu_wdata;
      end else if (off == 16'h0004) begin
        tx_push = 1'b1; tx_val = 8'h00; m_prog = 1'b1;
      end
    end
    if (tx_pop)  void'(m_txq.pop_front());
    if (tx_push) m_txq.push_back(tx_val);
    if (rx_pop)  void'(m_rxq.pop_front());
    if (rx_push) m_rxq.push_back(rx_data);
    m_cnt = m_cnt + 32'd1;
  endtask

  // One clock: check live outputs against the model, clock it, check registered outputs.
  task automatic do_cycle(input string tag);
    bit rdy_e, txv_e;
    #1;
    rdy_e = m_rdy();
    txv_e = !rst_in && (m_txq.size() > 0);
    chk1({tag, " cpu_rdy"}, cpu_rdy, rdy_e);
    chk1({tag, " rx_ready"}, rx_ready, rst_in || (m_rxq.size() < RXD));
    chk1({tag, " tx_valid"}, tx_valid, txv_e);
    if (txv_e) chk8({tag, " tx_data"}, tx_data, m_txq[0]);
    last_rdy = rdy_e;
    @(posedge clk_in);
    m_step(rdy_e);
    #1;
    if (m_rdata_known) chk8({tag, " cpu_rdata"}, cpu_rdata, m_rdata);
    chk1({tag, " prog_stop"}, prog_stop, m_prog);
    @(negedge clk_in);
  endtask

  task automatic set_idle();
    cpu_a = 32'h0003_0001; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_in = 1'b1;
    do_cycle("reset");
    rst_in = 1'b0;
  endtask

  task automatic exp_rdy(input string name, input logic v);
    #1;
    chk1(name, cpu_rdy, v);
  endtask

  task automatic io_wr(input logic [31:0] a, input logic [7:0] d);
    cpu_a = a; cpu_wr = 1'b1; cpu_wdata = d;
  endtask

  task automatic io_rd(input logic [31:0] a);
    cpu_a = a; cpu_wr = 1'b0; cpu_wdata = 8'h00;
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{32'h0000_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[2]  = '{32'hFFFC_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[3]  = '{32'h0003_0001, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[4]  = '{32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[5]  = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'hA5};
    vecs[6]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h41};
    vecs[7]  = '{32'h0003_0000, 1'b1, 8'h31, 1'b0, 8'h00, 1'b1, 8'h41};
    vecs[8]  = '{32'h0003_0008, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[9]  = '{32'h0002_0123, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[10] = '{32'h0000_0123, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A};
    pool = '{18'h00123, 18'h1FFFF, 18'h00000, 18'h2ABCD, 18'h10001};

    m_rdata_known = 1'b0; m_prog = 1'b0; last_rdy = 1'b1;
    m_cnt = 32'h0; m_snap = 32'h0; m_rdata = 8'h00;
    set_idle();
    rst_in = 1'b1;
    @(negedge clk_in);
    do_cycle("reset0");
    do_reset();
    chk8("reset cpu_rdata", cpu_rdata, 8'h00);
    chk1("reset prog_stop", prog_stop, 1'b0);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      cpu_a = vecs[i].a; cpu_wr = vecs[i].wr; cpu_wdata = vecs[i].wdata;
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd; tx_ready = 1'b0;
      exp_rdy($sformatf("vec%0d rdy", i), vecs[i].rdy);
      do_cycle($sformatf("vec%0d", i));
      chk8($sformatf("vec%0d rdata", i), cpu_rdata, vecs[i].rdata);
    end

    // RX empty stall: three idle cycles, then a push cycle that must not bypass
    do_reset();
    io_rd(32'h0003_0000);
    for (int i = 0; i < 4; i++) begin
      rx_valid = (i == 3); rx_data = 8'h41;
      exp_rdy($sformatf("rx stall %0d", i), 1'b0);
      do_cycle("rx_stall");
    end
    rx_valid = 1'b0;
    exp_rdy("rx complete rdy", 1'b1);
    do_cycle("rx_done");
    chk8("rx popped byte", cpu_rdata, 8'h41);
    exp_rdy("rx empty again", 1'b0);
    do_cycle("rx_empty");
    set_idle();
    do_cycle("idle");

    // TX full: eight accepted, ninth stalls even with tx_ready, completes after space frees
    do_reset();
    io_wr(32'h0003_0000, 8'h31);
    for (int i = 0; i < 8; i++) begin
      exp_rdy($sformatf("tx fill %0d", i), 1'b1);
      do_cycle("tx_fill");
    end
    exp_rdy("tx ninth stalls", 1'b0);
    do_cycle("tx_full");
    tx_ready = 1'b1;
    exp_rdy("tx full with tx_ready", 1'b0);
    do_cycle("tx_pop");
    tx_ready = 1'b0;
    exp_rdy("tx ninth completes", 1'b1);
    do_cycle("tx_ninth");
    set_idle();
    tx_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (tx_valid) begin
        cnt++;
        chk8("tx drain data", tx_data, 8'h31);
      end
      do_cycle("tx_drain");
    end
    chk32("tx drained bytes", cnt, 8);

    // Zero byte ignored; stop write emits 0x00 and latches prog_stop until reset
    do_reset();
    io_wr(32'h0003_0000, 8'h00);
    exp_rdy("zero write rdy", 1'b1);
    do_cycle("zero_wr");
    chk1("zero write no tx", tx_valid, 1'b0);
    io_wr(32'h0003_0004, 8'hFF);
    do_cycle("stop_wr");
    chk1("stop tx_valid", tx_valid, 1'b1);
    chk8("stop tx_data", tx_data, 8'h00);
    chk1("stop prog_stop", prog_stop, 1'b1);
    set_idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle("stop_hold");
    chk1("prog_stop sticky", prog_stop, 1'b1);
    chk1("stop byte drained", tx_valid, 1'b0);
    do_reset();
    chk1("prog_stop cleared", prog_stop, 1'b0);
    io_rd(32'h0000_0123);
    do_cycle("ram_keep");
    chk8("ram survives reset", cpu_rdata, 8'h5A);

    // Counter snapshot with the counter forced to a known value
    do_reset();
    io_rd(32'h0003_0004);
    force dut.cycle_cnt_r = 32'h1234_5678;
    m_cnt = 32'h1234_5678;
    do_cycle("snap4");
    release dut.cycle_cnt_r;
    chk8("snap byte0", cpu_rdata, 8'h78);
    io_rd(32'h0003_0005); do_cycle("snap5"); chk8("snap byte1", cpu_rdata, 8'h56);
    io_rd(32'h0003_0006); do_cycle("snap6"); chk8("snap byte2", cpu_rdata, 8'h34);
    io_rd(32'h0003_0007); do_cycle("snap7"); chk8("snap byte3", cpu_rdata, 8'h12);

    // Reset while a TX-full stall is pending discards the pending byte
    do_reset();
    io_wr(32'h0003_0000, 8'h77);
    for (int i = 0; i < 8; i++) do_cycle("rst_fill");
    exp_rdy("rst pending stall", 1'b0);
    do_cycle("rst_pend");
    rst_in = 1'b1;
    exp_rdy("rdy during reset", 1'b1);
    do_cycle("rst_mid");
    rst_in = 1'b0;
    chk1("tx empty after reset", tx_valid, 1'b0);
    set_idle();
    tx_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (tx_valid) cnt++;
      do_cycle("rst_drain");
    end
    chk32("pending byte never emitted", cnt, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 5; i++) begin
      io_wr({14'($urandom), pool[i]}, 8'($urandom));
      do_cycle("seed");
    end
    for (int n = 0; n < 3000; n++) begin
      bit hi_phase;
      hi_phase = ((n / 400) % 2) == 1;
      rst_in = ($urandom_range(0, 299) == 0);
      if (last_rdy) begin
        int k;
        k = $urandom_range(0, 9);
        case (k)
          0, 1: io_wr({14'($urandom), pool[$urandom_range(0, 4)]}, 8'($urandom));
          2, 3: io_rd({14'($urandom), pool[$urandom_range(0, 4)]});
          4, 5: io_rd({14'($urandom), 18'h30000});
          6:    io_rd({14'($urandom), 18'h30004 + 18'($urandom_range(0, 3))});
          7:    io_wr({14'($urandom), 18'h30000},
                      ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
          8:    io_wr({14'($urandom), ($urandom_range(0, 4) == 0) ? 18'h30004 : 18'h30000},
                      8'($urandom_range(1, 255)));
          default: begin
            cpu_a  = {14'($urandom), 18'h30008 + 18'($urandom_range(0, 8))};
            cpu_wr = 1'($urandom);
            cpu_wdata = 8'($urandom);
          end
        endcase
      end
      rx_valid = hi_phase ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
      rx_data  = 8'($urandom);
      tx_ready = hi_phase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      do_cycle("rnd");
    end
    rst_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
